// File: rtl/ram_multiport.sv
// ram_multiport: one write port and NRD registered read ports.
// Writes use byte enables. Each read port has a one-cycle valid strobe
// and an out-of-range flag. After reset the array is zero-filled
// (INIT state) before it accepts any access.
// Optional feature macro: RAM_MULTIPORT_BYPASS_EN.
//   Defined:   a read that hits the address being written on the same
//              edge returns the merged new word (write-first).
//   Undefined: that read returns the word stored before the edge
//              (read-before-write).
// Handshake: rd_en[p] is sampled at an edge. The result is presented from
// that edge until the next one, and rd_valid[p] marks it for that cycle
// only. The protocol has no ready/backpressure, and every accepted read
// returns one result. Accesses made while busy=1 are dropped silently.
module ram_multiport #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int NRD    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W/8-1:0]      wr_be,
  input  logic [DATA_W-1:0]        d_in,
  input  logic [NRD-1:0]           rd_en,
  input  logic [NRD*ADDR_W-1:0]    rd_addr,
  output logic [NRD*DATA_W-1:0]    d_out,
  output logic [NRD-1:0]           rd_valid,
  output logic [NRD-1:0]           rd_oob,
  output logic                     busy,
  output logic                     state_dbg
);

  localparam int                NBYTE    = DATA_W / 8;
  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W+1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   init_ptr;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               wr_in_range;
  logic [IDX_W-1:0]   wr_idx;
  logic               wr_fire;
  logic               rd_allowed;
  logic [DATA_W-1:0]  wr_merged;

  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign wr_idx      = wr_addr[IDX_W-1:0];
  assign wr_fire     = !reset && (state == ST_READY) && wr && wr_in_range;
  assign rd_allowed  = !reset && (state == ST_READY);

  // FSM state register: reset always restarts the zero-fill
  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  // FSM next state: leave INIT on the edge that clears the last word
  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  if (init_ptr == LAST_IDX) state_nxt = ST_READY;
      ST_READY: state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // FSM outputs: busy for the whole fill, raw state for debug
  always_comb begin
    busy      = (state == ST_INIT);
    state_dbg = state;
  end

  // Fill pointer walks the array once per edge while in INIT
  always_ff @(posedge clk) begin
    if (reset)                 init_ptr <= '0;
    else if (state == ST_INIT) init_ptr <= init_ptr + IDX_W'(1);
  end

  // Stored word with enabled lanes replaced by d_in; also used for forwarding
  always_comb begin
    wr_merged = mem[wr_idx];
    for (int b = 0; b < NBYTE; b++) begin
      if (wr_be[b]) wr_merged[b*8 +: 8] = d_in[b*8 +: 8];
    end
  end

  // Storage: zero-fill in INIT, otherwise byte-enabled writes in range only
  always_ff @(posedge clk) begin
    if (!reset && state == ST_INIT) mem[init_ptr] <= '0;
    else if (wr_fire)               mem[wr_idx]   <= wr_merged;
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              in_range;
    logic [DATA_W-1:0] word;
    logic [DATA_W-1:0] d_q;
    logic              valid_q;
    logic              oob_q;

    assign ra       = rd_addr[g*ADDR_W +: ADDR_W];
    assign in_range = {1'b0, ra} < DEPTH_W;

    // Word this port would capture; collision handling set by the build macro
    always_comb begin
      word = mem[ra[IDX_W-1:0]];
`ifdef RAM_MULTIPORT_BYPASS_EN
      if (wr_fire && (ra == wr_addr)) word = wr_merged;
`else
      word = mem[ra[IDX_W-1:0]];
`endif
    end

    // Read register: loads on an accepted read, holds data otherwise
    always_ff @(posedge clk) begin
      if (reset) begin
        d_q     <= '0;
        valid_q <= 1'b0;
        oob_q   <= 1'b0;
      end else if (rd_allowed && rd_en[g]) begin
        valid_q <= 1'b1;
        oob_q   <= !in_range;
        d_q     <= in_range ? word : '0;
      end else begin
        valid_q <= 1'b0;
        oob_q   <= 1'b0;
      end
    end

    assign d_out[g*DATA_W +: DATA_W] = d_q;
    assign rd_valid[g]               = valid_q;
    assign rd_oob[g]                 = oob_q;
  end

endmodule

// File: tb/tb_ram_multiport.sv
// Bench for ram_multiport at DATA_W=16, ADDR_W=4, DEPTH=12, NRD=2.
// Inputs are driven at the falling edge and outputs are sampled at the next
// falling edge. Expected read results are queued when a read is issued.
// They are popped when rd_valid appears.
module tb_ram_multiport;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 12;
  localparam int NRD    = 2;
  localparam int SB_W   = 18;  // {port, oob, data}

`ifdef RAM_MULTIPORT_BYPASS_EN
  localparam logic [15:0] COLL3 = 16'hBEEF;
  localparam logic [15:0] COLL0 = 16'h99CD;
`else
  localparam logic [15:0] COLL3 = 16'h0000;
  localparam logic [15:0] COLL0 = 16'hABCD;
`endif

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    wr;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W/8-1:0]     wr_be;
  logic [DATA_W-1:0]       d_in;
  logic [NRD-1:0]          rd_en;
  logic [NRD*ADDR_W-1:0]   rd_addr;
  logic [NRD*DATA_W-1:0]   d_out;
  logic [NRD-1:0]          rd_valid;
  logic [NRD-1:0]          rd_oob;
  logic                    busy;
  logic                    state_dbg;

  ram_multiport #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .NRD(NRD)
  ) dut (
    .clk(clk), .reset(reset), .wr(wr), .wr_addr(wr_addr), .wr_be(wr_be),
    .d_in(d_in), .rd_en(rd_en), .rd_addr(rd_addr), .d_out(d_out),
    .rd_valid(rd_valid), .rd_oob(rd_oob), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        w;
    logic [3:0]  wa;
    logic [1:0]  be;
    logic [15:0] d;
    logic [1:0]  re;
    logic [3:0]  a0;
    logic [3:0]  a1;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  eoob;
  } vec_t;

  vec_t            vecs [16];
  logic [SB_W-1:0] exp_q [$];
  logic [1:0]      exp_valid;
  logic [15:0]     last_d [2];
  int              total = 0;
  int              bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: compare everything the DUT shows after one edge
  task automatic sample(input logic exp_busy);
    logic [SB_W-1:0] e;
    check("busy", 32'(busy), 32'(exp_busy));
    check("rd_valid", 32'(rd_valid), 32'(exp_valid));
    for (int p = 0; p < NRD; p++) begin
      if (rd_valid[p]) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: got rd_valid[%0d]=1 expected no result", p);
        end else begin
          e = exp_q.pop_front();
          check("sb_port", 32'(p), 32'(e[17]));
          check("d_out", 32'(d_out[p*DATA_W +: DATA_W]), 32'(e[15:0]));
          check("rd_oob", 32'(rd_oob[p]), 32'(e[16]));
          last_d[p] = e[15:0];
        end
      end else begin
        check("rd_oob_idle", 32'(rd_oob[p]), 32'd0);
        check("d_out_hold", 32'(d_out[p*DATA_W +: DATA_W]), 32'(last_d[p]));
      end
    end
  endtask

  // driver: one clock cycle of stimulus plus the check of its result
  task automatic cycle(input logic w, input logic [3:0] wa, input logic [1:0] be,
                       input logic [15:0] d, input logic [1:0] re,
                       input logic [3:0] a0, input logic [3:0] a1,
                       input logic [15:0] e0, input logic [15:0] e1,
                       input logic [1:0] eoob, input logic ready, input logic exp_busy);
    wr      = w;
    wr_addr = wa;
    wr_be   = be;
    d_in    = d;
    rd_en   = re;
    rd_addr = {a1, a0};
    exp_valid = ready ? re : 2'b00;
    if (ready && re[0]) exp_q.push_back({1'b0, eoob[0], e0});
    if (ready && re[1]) exp_q.push_back({1'b1, eoob[1], e1});
    @(negedge clk);
    sample(exp_busy);
  endtask

  task automatic do_reset(input int n);
    reset     = 1'b1;
    wr        = 1'b0;
    rd_en     = 2'b11;
    exp_valid = 2'b00;
    exp_q.delete();
    last_d[0] = 16'h0;
    last_d[1] = 16'h0;
    repeat (n) begin
      @(negedge clk);
      sample(1'b1);
    end
    reset = 1'b0;
  endtask

  // fill edges with random (ignored) writes and reads; busy drops after done_at
  task automatic fill_run(input int n, input int done_at);
    for (int k = 1; k <= n; k++) begin
      cycle(1'b1, 4'($urandom_range(0, 15)), 2'b11, 16'($urandom_range(1, 65535)),
            2'b11, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            16'h0, 16'h0, 2'b00, 1'b0, (k < done_at));
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr      = 1'b0;
    wr_addr = '0;
    wr_be   = '0;
    d_in    = '0;
    rd_en   = '0;
    rd_addr = '0;

    //            w     wa     be     d         re     a0     a1     e0        e1        eoob
    vecs[0]  = '{1'b1, 4'd0,  2'b11, 16'hABCD, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 2'b00};
    vecs[1]  = '{1'b1, 4'd1,  2'b11, 16'h1234, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 2'b00};
    vecs[2]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b11, 4'd0,  4'd1,  16'hABCD, 16'h1234, 2'b00};
    vecs[3]  = '{1'b1, 4'd1,  2'b01, 16'h5678, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 2'b00};
    vecs[4]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b01, 4'd1,  4'd0,  16'h1278, 16'h0000, 2'b00};
    vecs[5]  = '{1'b1, 4'd3,  2'b11, 16'hBEEF, 2'b01, 4'd3,  4'd0,  COLL3,    16'h0000, 2'b00};
    vecs[6]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b01, 4'd3,  4'd0,  16'hBEEF, 16'h0000, 2'b00};
    vecs[7]  = '{1'b1, 4'd13, 2'b11, 16'hDEAD, 2'b11, 4'd1,  4'd13, 16'h1278, 16'h0000, 2'b10};
    vecs[8]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b11, 4'd13, 4'd12, 16'h0000, 16'h0000, 2'b11};
    vecs[9]  = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b00, 4'd0,  4'd0,  16'h0000, 16'h0000, 2'b00};
    vecs[10] = '{1'b1, 4'd0,  2'b00, 16'hFFFF, 2'b01, 4'd0,  4'd0,  16'hABCD, 16'h0000, 2'b00};
    vecs[11] = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b11, 4'd0,  4'd0,  16'hABCD, 16'hABCD, 2'b00};
    vecs[12] = '{1'b1, 4'd0,  2'b10, 16'h9900, 2'b10, 4'd0,  4'd0,  16'h0000, COLL0,    2'b00};
    vecs[13] = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b11, 4'd0,  4'd11, 16'h99CD, 16'h0000, 2'b00};
    vecs[14] = '{1'b1, 4'd11, 2'b11, 16'h7777, 2'b01, 4'd14, 4'd0,  16'h0000, 16'h0000, 2'b01};
    vecs[15] = '{1'b0, 4'd0,  2'b00, 16'h0000, 2'b10, 4'd0,  4'd11, 16'h0000, 16'h7777, 2'b00};

    // zero-fill: 2 reset cycles, busy for exactly DEPTH edges, all words zero
    do_reset(2);
    fill_run(DEPTH, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b0, 4'd0, 2'b00, 16'h0, 2'b11, 4'(i), 4'(DEPTH - 1 - i),
            16'h0, 16'h0, 2'b00, 1'b1, 1'b0);
    end

    // table: dual read, byte enable, collision, out-of-range, hold
    for (int v = 0; v < 16; v++) begin
      cycle(vecs[v].w, vecs[v].wa, vecs[v].be, vecs[v].d, vecs[v].re,
            vecs[v].a0, vecs[v].a1, vecs[v].e0, vecs[v].e1, vecs[v].eoob,
            1'b1, 1'b0);
    end

    // reset mid-fill: reset lands on fill edge 5, then a full fill again
    do_reset(1);
    fill_run(4, 99);
    do_reset(1);
    fill_run(2, 99);
    cycle(1'b1, 4'd2, 2'b11, 16'h1111, 2'b01, 4'd2, 4'd0,
          16'h0, 16'h0, 2'b00, 1'b0, 1'b1);
    fill_run(DEPTH - 3, DEPTH - 3);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 2'b11, 4'd2, 4'd11,
          16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);
    cycle(1'b0, 4'd0, 2'b00, 16'h0, 2'b01, 4'd0, 4'd0,
          16'h0000, 16'h0000, 2'b00, 1'b1, 1'b0);

    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_multiport.md
# ram_multiport

Parametrised single-write, N-read synchronous RAM: the next generation of the 16-bit two-read-port `ram8b`, generalised in data width, depth and read-port count. Adds byte-enable writes, registered reads with a per-port valid strobe, out-of-range detection and a post-reset zero-fill sequencer. Sits beside `ram8b` as the shared storage primitive for register-file and buffer use; clients issue a read and take its result one cycle later.

## Interface

- `DATA_W`, 16, data word width; must be a multiple of 8.
- `ADDR_W`, 8, address width.
- `DEPTH`, 256, number of words; must satisfy 1 ≤ DEPTH ≤ 2**ADDR_W.
- `NRD`, 2, number of independent read ports; must be ≥ 1.

Ports:

- `clk`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr`  in  1  write strobe.
- `wr_addr`  in  ADDR_W  write address.
- `wr_be`  in  DATA_W/8  byte enables; bit i enables `d_in[8i+7:8i]`.
- `d_in`  in  DATA_W  write data.
- `rd_en`  in  NRD  per-port read strobe.
- `rd_addr`  in  NRD*ADDR_W  packed read addresses; port p uses `[p*ADDR_W +: ADDR_W]`.
- `d_out`  out  NRD*DATA_W  packed registered read data; port p uses `[p*DATA_W +: DATA_W]`.
- `rd_valid`  out  NRD  per-port one-cycle strobe marking a read result.
- `rd_oob`  out  NRD  per-port flag, qualified by `rd_valid`: the read address was ≥ DEPTH.
- `busy`  out  1  high during reset and zero-fill; writes and reads are ignored while high.

## Operation

- FSM states are INIT and READY.
  - `reset` = 1 at an edge: state becomes INIT and `init_ptr` becomes 0. `d_out`, `rd_valid` and `rd_oob` become all zeros; `busy` becomes 1.
  - INIT: each edge writes all-zeros at `init_ptr` and increments it.
  - INIT to READY: the edge that writes `DEPTH-1` moves the FSM to READY and clears `busy`.
- `reset` asserted at any point, including mid-INIT, restarts the fill at address 0.
- Write, in READY only: at an edge with `wr`=1 and `wr_addr` < DEPTH, each byte lane with `wr_be`=1 is updated from `d_in`. Other lanes are unchanged.
  - `wr_addr` ≥ DEPTH: the write is dropped. No aliasing into other locations.
  - `wr_be` = 0: no-op.
- Read, in READY only, per port p with `rd_en[p]`=1 at an edge:
  - `d_out` port p is loaded with `mem[rd_addr_p]`, `rd_valid[p]` is set to 1 and `rd_oob[p]` to 0.
  - If `rd_addr_p` ≥ DEPTH: `d_out` port p is loaded with 0 and `rd_oob[p]` is set to 1.
- `rd_en[p]`=0, or any read in INIT:
  - `rd_valid[p]` becomes 0 and `rd_oob[p]` becomes 0.
  - `d_out` port p holds its previous value.
- Ports are fully independent. Any number of ports may read the same address in the same cycle.
- Same-address write/read collision in the same cycle: behaviour is set by Configuration.

## Timing

- Read latency is 1 cycle: `rd_en` is sampled at edge k, and `d_out`/`rd_valid`/`rd_oob` are valid from edge k until edge k+1.
- Back-to-back reads on every cycle are supported. Throughput is 1 read per port per cycle.
- A write is committed at edge k. A read issued at edge k+1 or later returns the new data.
- After `reset` is deasserted, `busy` stays 1 for exactly DEPTH edges; the first READY edge follows.
- Reset values: `d_out` = 0, `rd_valid` = 0, `rd_oob` = 0, `busy` = 1.

## Configuration

- Macro `RAM_MULTIPORT_BYPASS_EN` selects collision behaviour when a write and a read hit the same in-range address on the same edge.
- Defined: write-first forwarding. The read returns the merged word: enabled lanes from `d_in`, disabled lanes from the stored word.
- Undefined: read-before-write. The read returns the stored word as it was before the edge.
- The macro has no effect on out-of-range or INIT behaviour.

## Test plan

All scenarios use DATA_W=16, ADDR_W=4, DEPTH=12, NRD=2.

1. Zero-fill: hold `reset` for 2 cycles, release, then read all 12 addresses -> `busy` is 1 for exactly 12 edges, then 0; every read returns 0x0000 with `rd_valid`=1.
2. Dual read: write 0xABCD@0 and 0x1234@1 with `wr_be`=2'b11, then read port0@0 and port1@1 on the same edge -> next cycle `d_out` = {0x1234, 0xABCD}, `rd_valid`=2'b11.
3. Byte enable: write 0x5678@1 with `wr_be`=2'b01, then read@1 -> 0x1278.
4. Collision: with 0x0000@3, write 0xBEEF@3 while port0 reads @3 -> 0xBEEF with the macro defined, 0x0000 without; a read one cycle later returns 0xBEEF in both builds.
5. Out-of-range: write 0xDEAD@13, read port1@13 and port0@1 -> port1 `d_out`=0x0000 with `rd_oob[1]`=1; port0 returns 0x1278, unchanged.
6. Reset mid-fill: assert `reset` at fill edge 5, release -> `busy` held for a full 12 edges again; a write of 0x1111@2 issued while busy is ignored (read@2 returns 0x0000).
